// File: rtl/sub4_serial.sv
`default_nettype none
// ============================================================================
// Module      : sub4_serial
// Description : Bit-serial unsigned subtractor (LSB first, one bit per cycle)
//               with valid/ready handshakes on both sides. Define
//               SUB4_SERIAL_CHAIN_EN to allow in_chain to select the previous
//               borrow-out as borrow-in.
// Revision    : 1.0 - initial release
// ============================================================================
module sub4_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_bout
);

    localparam int c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_part;
    logic               r_br;
    logic [c_cnt_w-1:0] r_cnt;

    logic w_accept;
    logic w_last;
    logic w_d;
    logic w_br_next;
    logic w_bin_sel;

    // Full subtractor on the current LSB of the operand shift registers.
    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_last    = (r_cnt == c_last);
    assign w_accept  = in_valid & in_ready;

`ifdef SUB4_SERIAL_CHAIN_EN
    // out_bout always holds the borrow of the last completed operation.
    assign w_bin_sel = in_chain ? out_bout : in_bin;
`else
    logic w_unused;
    assign w_unused  = in_chain;
    assign w_bin_sel = in_bin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Result outputs load only on the final bit so partial sums never show.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_part   <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            out_diff <= '0;
            out_bout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= in_a;
                        r_b   <= in_b;
                        r_br  <= w_bin_sel;
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_br   <= w_br_next;
                    r_part <= {w_d, r_part[WIDTH-1:1]};
                    if (w_last) begin
                        r_cnt    <= '0;
                        out_diff <= {w_d, r_part[WIDTH-1:1]};
                        out_bout <= w_br_next;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sub4_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub4_serial
// Description : Scoreboard bench for sub4_serial (default WIDTH).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub4_serial;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_bin;
    logic         in_chain;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_diff;
    logic         out_bout;

    int           n_checks;
    int           n_fail;
    logic [W:0]   sb[$];
    logic         m_last_bout;

    sub4_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_bin    (in_bin),
        .in_chain  (in_chain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff),
        .out_bout  (out_bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic chain, input int hold);
        int         cyc;
        logic       bin_eff;
        logic [W:0] exp;
        logic [W:0] got;
        logic [W:0] held;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
`ifdef SUB4_SERIAL_CHAIN_EN
        bin_eff = chain ? m_last_bout : bin;
`else
        bin_eff = bin;
`endif
        exp = ({1'b0, a} - {1'b0, b}) - {{W{1'b0}}, bin_eff};
        sb.push_back(exp);
        in_a     = a;
        in_b     = b;
        in_bin   = bin;
        in_chain = chain;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_bin   = 1'($urandom);
        in_chain = 1'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(W));
        held = {out_bout, out_diff};
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            tick();
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_stable", 32'({out_bout, out_diff}), 32'(held));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got = {out_bout, out_diff};
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            check("result", 32'(got), 32'(exp));
            m_last_bout = exp[W];
        end else begin
            check("sb_nonempty", 32'd0, 32'd1);
        end
        tick();
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_hold_result", 32'({out_bout, out_diff}), 32'(got));
    endtask

    initial begin
        logic seen_valid;
        n_checks    = 0;
        n_fail      = 0;
        m_last_bout = 1'b0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        in_bin      = 1'b0;
        in_chain    = 1'b0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(out_diff), 32'd0);
        check("rst_bout", 32'(out_bout), 32'd0);

        // out_ready while idle must not disturb anything.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_ready_noop", 32'({in_ready, out_valid}), 32'b10);

        run_op(4'd7, 4'd3, 1'b0, 1'b0, 0);
        run_op(4'd3, 4'd7, 1'b0, 1'b0, 0);
        run_op(4'd0, 4'd0, 1'b1, 1'b0, 1);
        run_op(4'd9, 4'd4, 1'b0, 1'b0, 10);
        run_op(4'd0, 4'd1, 1'b0, 1'b0, 0);
        run_op(4'd5, 4'd2, 1'b0, 1'b1, 0);
        for (int k = 0; k < 8; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), k % 3);
        end

        // Leave a nonzero result behind, then reset mid-shift.
        run_op(4'd2, 4'd9, 1'b0, 1'b0, 0);
        in_a     = 4'd6;
        in_b     = 4'd1;
        in_bin   = 1'b0;
        in_chain = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        m_last_bout = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_diff", 32'(out_diff), 32'd0);
        check("midrst_bout", 32'(out_bout), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen_valid |= out_valid;
        end
        check("midrst_no_result", 32'(seen_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        run_op(4'd15, 4'd15, 1'b0, 1'b0, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
